mcast_inport: RTL and testbench



---
 rtl/mcast_inport_pkg.sv | 23 ++
 rtl/mcast_ibuf.sv | 25 ++
 rtl/mcast_inport.sv | 171 +++++++++++++++++
 tb/tb_mcast_inport.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcast_inport_pkg.sv
// Shared types and constants for the multicast input-port controller.
package mcast_inport_pkg;

   localparam int unsigned NumPorts = 5;
   localparam int unsigned PortW    = 3;
   localparam int unsigned StatusW  = 2;

   typedef enum logic [1:0] {
      StIdle,
      StRoute,
      StSend,
      StDrop
   } mi_state_e;

   typedef struct packed {
      logic                head;
      logic                tail;
      logic [NumPorts-1:0] dst;
   } flit_meta_t;

   localparam int unsigned MetaW = $bits(flit_meta_t);

endpackage

// File: rtl/mcast_ibuf.sv
// Flit buffer: register array with one synchronous write port and one asynchronous read port.
module mcast_ibuf #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned W     = 39,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [W-1:0]  wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [W-1:0]  rdata_o
);

   logic [W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mcast_inport.sv
// Input-port controller: buffers packets and replays each one once per destination port,
// lowest port first, freeing buffer space only after the final copy.
module mcast_inport
   import mcast_inport_pkg::*;
#(
   parameter int unsigned PORTID = 0,
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned DW     = 32
) (
   input  logic                clk,
   input  logic                rst_,
   input  logic [DW-1:0]       in_data,
   input  logic                in_valid,
   input  logic                in_head,
   input  logic                in_tail,
   input  logic [NumPorts-1:0] dst_map,
   output logic                in_ready,
   output logic [PortW-1:0]    port,
   output logic                req,
   output logic [StatusW-1:0]  multab,
   input  logic [NumPorts-1:0] grt,
   output logic [DW-1:0]       out_data,
   output logic                out_valid
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam int unsigned EntW = DW + MetaW;

   if (PORTID >= NumPorts || DEPTH != (1 << PtrW)) begin : g_bad_param
      $error("mcast_inport: PORTID must be < 5 and DEPTH a power of two");
   end

   function automatic logic [PortW-1:0] lsb_index(input logic [NumPorts-1:0] m);
      lsb_index = '0;
      for (int i = NumPorts - 1; i >= 0; i--) begin
         if (m[i]) lsb_index = PortW'(i);
      end
   endfunction

   function automatic logic multi_dst(input logic [NumPorts-1:0] m);
      return |(m & (m - NumPorts'(1)));
   endfunction

   mi_state_e           state_q, state_d;
   logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]     pkt_ptr_q, pkt_ptr_d;
   logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]     count_q, count_d;
   logic [NumPorts-1:0] pending_q, pending_d;
   logic [NumPorts-1:0] dmask_q, dmask_d;

   logic                wr_en;
   logic [PtrW-1:0]     rd_addr;
   logic [PtrW-1:0]     rd_off;
   logic                flit_avail;
   logic                xfer;
   logic                pkt_done;
   logic [CntW-1:0]     free_len;
   logic                is_multi;
   flit_meta_t          wr_meta;
   flit_meta_t          rd_meta;
   logic [EntW-1:0]     rd_ent;
   logic [DW-1:0]       rd_data;

   assign wr_meta = '{head: in_head, tail: in_tail, dst: (in_head ? dst_map : '0)};

   mcast_ibuf #(
      .DEPTH (DEPTH),
      .W     (EntW)
   ) u_ibuf (
      .clk_i   (clk),
      .we_i    (wr_en),
      .waddr_i (wr_ptr_q),
      .wdata_i ({in_data, wr_meta}),
      .raddr_i (rd_addr),
      .rdata_o (rd_ent)
   );

   assign rd_meta = rd_ent[MetaW-1:0];
   assign rd_data = rd_ent[EntW-1:MetaW];

   always_comb begin
      in_ready   = rst_ && (count_q < CntW'(DEPTH));
      wr_en      = in_valid && in_ready;
      rd_addr    = (state_q == StSend) ? rd_ptr_q : pkt_ptr_q;
      // Offset from the packet head rather than rd_ptr != wr_ptr, so a full buffer
      // (wr_ptr == pkt_ptr) still reports its flits as available.
      rd_off     = rd_ptr_q - pkt_ptr_q;
      flit_avail = {1'b0, rd_off} < count_q;
      is_multi   = multi_dst(dmask_q);
      req        = (state_q == StSend);
      port       = req ? lsb_index(pending_q) : '0;
      multab     = req ? {is_multi, ~is_multi} : '0;
      xfer       = rst_ && req && grt[port] && flit_avail;
      out_valid  = xfer;
      out_data   = xfer ? rd_data : '0;
   end

   always_comb begin
      state_d   = state_q;
      wr_ptr_d  = wr_ptr_q + PtrW'(wr_en);
      pkt_ptr_d = pkt_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      pending_d = pending_q;
      dmask_d   = dmask_q;
      free_len  = '0;
      pkt_done  = 1'b0;

      unique case (state_q)
         StIdle: ;
         StRoute: begin
            pending_d = rd_meta.dst;
            dmask_d   = rd_meta.dst;
            rd_ptr_d  = pkt_ptr_q;
            // A stray non-head flit at the packet pointer is discarded like a zero mask.
            state_d   = (rd_meta.head && rd_meta.dst != '0) ? StSend : StDrop;
         end
         StSend: begin
            if (xfer) begin
               rd_ptr_d = rd_ptr_q + PtrW'(1);
               if (rd_meta.tail) begin
                  pending_d = pending_q & ~(NumPorts'(1) << port);
                  if (pending_d != '0) begin
                     rd_ptr_d = pkt_ptr_q;
                  end else begin
                     pkt_ptr_d = rd_ptr_q + PtrW'(1);
                     free_len  = {1'b0, rd_off} + CntW'(1);
                     pkt_done  = 1'b1;
                  end
               end
            end
         end
         StDrop: begin
            if (count_q != '0) begin
               pkt_ptr_d = pkt_ptr_q + PtrW'(1);
               free_len  = CntW'(1);
               pkt_done  = rd_meta.tail;
            end
         end
         default: state_d = StIdle;
      endcase

      count_d = count_q + CntW'(wr_en) - free_len;

      if (pkt_done || state_q == StIdle) begin
         state_d = (count_d != '0) ? StRoute : StIdle;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_) begin
         state_q   <= StIdle;
         wr_ptr_q  <= '0;
         pkt_ptr_q <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         pending_q <= '0;
         dmask_q   <= '0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         pkt_ptr_q <= pkt_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         pending_q <= pending_d;
         dmask_q   <= dmask_d;
      end
   end

endmodule

// File: tb/tb_mcast_inport.sv
// Directed bench for mcast_inport: unicast, multicast, grant stall, full buffer, drop, reset.
module tb_mcast_inport;
   import mcast_inport_pkg::*;

   logic        clk = 1'b0;
   logic        rst_;
   logic [31:0] in_data;
   logic        in_valid, in_head, in_tail;
   logic [4:0]  dst_map;
   logic        in_ready;
   logic [2:0]  port;
   logic        req;
   logic [1:0]  multab;
   logic [4:0]  grt;
   logic [31:0] out_data;
   logic        out_valid;

   int checks   = 0;
   int failures = 0;

   logic [2:0]  mc_port [6];
   logic [31:0] dval;

   mcast_inport #(
      .PORTID (0),
      .DEPTH  (8),
      .DW     (32)
   ) dut (
      .clk       (clk),
      .rst_      (rst_),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_head   (in_head),
      .in_tail   (in_tail),
      .dst_map   (dst_map),
      .in_ready  (in_ready),
      .port      (port),
      .req       (req),
      .multab    (multab),
      .grt       (grt),
      .out_data  (out_data),
      .out_valid (out_valid)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_cyc(input string tag, input logic e_req, input logic [2:0] e_port,
                          input logic [1:0] e_mt, input logic e_ov, input logic [31:0] e_od);
      chk({tag, "_req"}, 32'(req), 32'(e_req));
      chk({tag, "_port"}, 32'(port), 32'(e_port));
      chk({tag, "_multab"}, 32'(multab), 32'(e_mt));
      chk({tag, "_ovalid"}, 32'(out_valid), 32'(e_ov));
      chk({tag, "_odata"}, out_data, e_od);
   endtask

   task automatic drv(input logic v, input logic h, input logic t, input logic [31:0] d,
                      input logic [4:0] m);
      in_valid = v;
      in_head  = h;
      in_tail  = t;
      in_data  = d;
      dst_map  = m;
   endtask

   initial begin
      mc_port = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd4, 3'd4};
      rst_ = 1'b0;
      grt  = 5'b0;
      drv(1'b0, 1'b0, 1'b0, 32'h0, 5'b0);

      // Reset state
      tick();
      tick();
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk_cyc("rst", 1'b0, 3'd0, 2'b00, 1'b0, 32'h0);
      chk("rst_state", 32'(dut.state_q), 32'(StIdle));
      chk("rst_count", 32'(dut.count_q), 32'd0);
      rst_ = 1'b1;
      settle();
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);

      // Unicast 3 flits to port 2
      grt = 5'b00100;
      drv(1'b1, 1'b1, 1'b0, 32'hA000_0000, 5'b00100);
      settle();
      chk_cyc("uc_n", 1'b0, 3'd0, 2'b00, 1'b0, 32'h0);
      tick();
      drv(1'b1, 1'b0, 1'b0, 32'hA000_0001, 5'b0);
      settle();
      chk_cyc("uc_n1", 1'b0, 3'd0, 2'b00, 1'b0, 32'h0);
      chk("uc_n1_state", 32'(dut.state_q), 32'(StRoute));
      tick();
      drv(1'b1, 1'b0, 1'b1, 32'hA000_0002, 5'b0);
      settle();
      chk_cyc("uc_n2", 1'b1, 3'd2, 2'b01, 1'b1, 32'hA000_0000);
      tick();
      drv(1'b0, 1'b0, 1'b0, 32'h0, 5'b0);
      settle();
      chk_cyc("uc_n3", 1'b1, 3'd2, 2'b01, 1'b1, 32'hA000_0001);
      tick();
      settle();
      chk_cyc("uc_n4", 1'b1, 3'd2, 2'b01, 1'b1, 32'hA000_0002);
      tick();
      settle();
      chk_cyc("uc_end", 1'b0, 3'd0, 2'b00, 1'b0, 32'h0);
      chk("uc_end_count", 32'(dut.count_q), 32'd0);

      // Multicast 2 flits to ports 1,2,4
      grt = 5'b11111;
      drv(1'b1, 1'b1, 1'b0, 32'hB000_0000, 5'b10110);
      tick();
      drv(1'b1, 1'b0, 1'b1, 32'hB000_0001, 5'b0);
      settle();
      chk("mc_route_req", 32'(req), 32'd0);
      tick();
      drv(1'b0, 1'b0, 1'b0, 32'h0, 5'b0);
      for (int i = 0; i < 6; i++) begin
         settle();
         dval = 32'hB000_0000 + 32'(i % 2);
         chk_cyc($sformatf("mc%0d", i), 1'b1, mc_port[i], 2'b10, 1'b1, dval);
         tick();
      end
      settle();
      chk_cyc("mc_end", 1'b0, 3'd0, 2'b00, 1'b0, 32'h0);
      chk("mc_end_count", 32'(dut.count_q), 32'd0);

      // Grant stall for 5 cycles mid-packet, port 0
      grt = 5'b00001;
      drv(1'b1, 1'b1, 1'b0, 32'hC000_0000, 5'b00001);
      tick();
      drv(1'b1, 1'b0, 1'b0, 32'hC000_0001, 5'b0);
      tick();
      drv(1'b1, 1'b0, 1'b1, 32'hC000_0002, 5'b0);
      settle();
      chk_cyc("st_c0", 1'b1, 3'd0, 2'b01, 1'b1, 32'hC000_0000);
      tick();
      drv(1'b0, 1'b0, 1'b0, 32'h0, 5'b0);
      grt = 5'b00000;
      for (int i = 0; i < 5; i++) begin
         settle();
         chk_cyc($sformatf("stall%0d", i), 1'b1, 3'd0, 2'b01, 1'b0, 32'h0);
         chk($sformatf("stall%0d_rdptr", i), 32'(dut.rd_ptr_q), 32'd6);
         tick();
      end
      grt = 5'b00001;
      settle();
      chk_cyc("st_c1", 1'b1, 3'd0, 2'b01, 1'b1, 32'hC000_0001);
      tick();
      settle();
      chk_cyc("st_c2", 1'b1, 3'd0, 2'b01, 1'b1, 32'hC000_0002);
      tick();
      settle();
      chk_cyc("st_end", 1'b0, 3'd0, 2'b00, 1'b0, 32'h0);

      // Full buffer: two 4-flit packets (port 3, then port 1) with grant withheld
      grt = 5'b00000;
      for (int k = 0; k < 8; k++) begin
         drv(1'b1, (k == 0 || k == 4), (k == 3 || k == 7), 32'hD000_0000 + 32'(k),
             (k == 0) ? 5'b01000 : ((k == 4) ? 5'b00010 : 5'b00000));
         settle();
         chk($sformatf("full_wr%0d_rdy", k), 32'(in_ready), 32'd1);
         tick();
      end
      drv(1'b0, 1'b0, 1'b0, 32'h0, 5'b0);
      settle();
      chk("full_rdy", 32'(in_ready), 32'd0);
      chk("full_count", 32'(dut.count_q), 32'd8);
      chk_cyc("full_hold", 1'b1, 3'd3, 2'b01, 1'b0, 32'h0);
      grt = 5'b01011;
      for (int k = 0; k < 4; k++) begin
         settle();
         chk_cyc($sformatf("full_d%0d", k), 1'b1, 3'd3, 2'b01, 1'b1, 32'hD000_0000 + 32'(k));
         chk($sformatf("full_d%0d_rdy", k), 32'(in_ready), 32'd0);
         tick();
      end
      settle();
      chk("full_route_req", 32'(req), 32'd0);
      chk("full_route_rdy", 32'(in_ready), 32'd1);
      chk("full_route_count", 32'(dut.count_q), 32'd4);
      tick();
      for (int k = 4; k < 8; k++) begin
         if (k == 7) drv(1'b1, 1'b1, 1'b1, 32'h6000_0000, 5'b00001);
         settle();
         chk_cyc($sformatf("full_d%0d", k), 1'b1, 3'd1, 2'b01, 1'b1, 32'hD000_0000 + 32'(k));
         tick();
      end
      drv(1'b0, 1'b0, 1'b0, 32'h0, 5'b0);
      settle();
      chk("free_wr_count", 32'(dut.count_q), 32'd1);
      chk("free_wr_state", 32'(dut.state_q), 32'(StRoute));
      tick();
      settle();
      chk_cyc("free_wr_g0", 1'b1, 3'd0, 2'b01, 1'b1, 32'h6000_0000);
      tick();
      settle();
      chk_cyc("free_wr_end", 1'b0, 3'd0, 2'b00, 1'b0, 32'h0);
      chk("free_wr_end_count", 32'(dut.count_q), 32'd0);

      // Zero mask packet dropped, following unicast served
      grt = 5'b00100;
      drv(1'b1, 1'b1, 1'b0, 32'h7000_0000, 5'b00000);
      tick();
      drv(1'b1, 1'b0, 1'b1, 32'h7000_0001, 5'b0);
      settle();
      chk("zm_route_req", 32'(req), 32'd0);
      tick();
      drv(1'b1, 1'b1, 1'b1, 32'h8000_0000, 5'b00100);
      settle();
      chk("zm_drop0_req", 32'(req), 32'd0);
      chk("zm_drop0_state", 32'(dut.state_q), 32'(StDrop));
      tick();
      drv(1'b0, 1'b0, 1'b0, 32'h0, 5'b0);
      settle();
      chk_cyc("zm_drop1", 1'b0, 3'd0, 2'b00, 1'b0, 32'h0);
      chk("zm_drop1_state", 32'(dut.state_q), 32'(StDrop));
      tick();
      settle();
      chk("zm_route2_req", 32'(req), 32'd0);
      chk("zm_route2_state", 32'(dut.state_q), 32'(StRoute));
      chk("zm_route2_count", 32'(dut.count_q), 32'd1);
      tick();
      settle();
      chk_cyc("zm_i0", 1'b1, 3'd2, 2'b01, 1'b1, 32'h8000_0000);
      tick();
      settle();
      chk_cyc("zm_end", 1'b0, 3'd0, 2'b00, 1'b0, 32'h0);
      chk("zm_end_count", 32'(dut.count_q), 32'd0);

      // Reset during second copy of a multicast to ports 0,1
      grt = 5'b11111;
      drv(1'b1, 1'b1, 1'b0, 32'h9000_0000, 5'b00011);
      tick();
      drv(1'b1, 1'b0, 1'b0, 32'h9000_0001, 5'b0);
      tick();
      drv(1'b1, 1'b0, 1'b1, 32'h9000_0002, 5'b0);
      settle();
      chk_cyc("rm_j0", 1'b1, 3'd0, 2'b10, 1'b1, 32'h9000_0000);
      tick();
      drv(1'b0, 1'b0, 1'b0, 32'h0, 5'b0);
      settle();
      chk_cyc("rm_j1", 1'b1, 3'd0, 2'b10, 1'b1, 32'h9000_0001);
      tick();
      settle();
      chk_cyc("rm_j2", 1'b1, 3'd0, 2'b10, 1'b1, 32'h9000_0002);
      tick();
      settle();
      chk_cyc("rm_copy2", 1'b1, 3'd1, 2'b10, 1'b1, 32'h9000_0000);
      rst_ = 1'b0;
      tick();
      settle();
      chk("rm_rst_rdy", 32'(in_ready), 32'd0);
      chk_cyc("rm_rst", 1'b0, 3'd0, 2'b00, 1'b0, 32'h0);
      chk("rm_rst_state", 32'(dut.state_q), 32'(StIdle));
      chk("rm_rst_count", 32'(dut.count_q), 32'd0);
      rst_ = 1'b1;
      tick();
      drv(1'b1, 1'b1, 1'b1, 32'h5000_0000, 5'b10000);
      settle();
      chk("rm_new_rdy", 32'(in_ready), 32'd1);
      tick();
      drv(1'b0, 1'b0, 1'b0, 32'h0, 5'b0);
      settle();
      chk("rm_new_route_req", 32'(req), 32'd0);
      tick();
      settle();
      chk_cyc("rm_new_k0", 1'b1, 3'd4, 2'b01, 1'b1, 32'h5000_0000);
      tick();
      settle();
      chk_cyc("rm_new_end", 1'b0, 3'd0, 2'b00, 1'b0, 32'h0);
      chk("rm_new_end_count", 32'(dut.count_q), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
